// File: rtl/lc3_regfile_wb.sv
// LC-3 architectural register file with writeback commit, write-first read bypass,
// N/Z/P condition codes and a per-register pending-write scoreboard for decode stalls.
module lc3_regfile_wb #(
    parameter int DW   = 16,
    parameter int CNTW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [19:0]   I_WBctl,
    input  logic [2:0]    I_SR1,
    input  logic [2:0]    I_SR2,
    input  logic          I_SR1use,
    input  logic          I_SR2use,
    input  logic          I_issue,
    input  logic [2:0]    I_issueDR,
    output logic [DW-1:0] O_SR1data,
    output logic [DW-1:0] O_SR2data,
    output logic [2:0]    O_CC,
    output logic          O_hazard,
    output logic          O_err
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic          wb_en;
    logic [2:0]    wb_reg;
    logic [DW-1:0] wb_data;

    assign wb_en   = I_WBctl[19];
    assign wb_reg  = I_WBctl[18:16];
    assign wb_data = I_WBctl[DW-1:0];

    logic [DW-1:0]   regs_q [8];
    logic [DW-1:0]   regs_d [8];
    logic [CNTW-1:0] cnt_q  [8];
    logic [CNTW-1:0] cnt_d  [8];
    logic [2:0]      cc_q, cc_d;
    logic            err_q, err_d;
    logic [7:0]      iss_vec, wb_vec;

    assign iss_vec = I_issue ? (8'b1 << I_issueDR) : 8'b0;
    assign wb_vec  = wb_en   ? (8'b1 << wb_reg)    : 8'b0;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        cc_d = cc_q;
        if (wb_en) begin
            regs_d[wb_reg] = wb_data;
            cc_d = {wb_data[DW-1], wb_data == '0, ~wb_data[DW-1] & (wb_data != '0)};
        end
    end

    // Issue and writeback to the same register cancel; protocol violations hold the count.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (iss_vec[i] && !wb_vec[i]) begin
                if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (wb_vec[i] && !iss_vec[i]) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            cc_q  <= 3'b010;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            cc_q  <= cc_d;
            err_q <= err_d;
        end
    end

    assign O_SR1data = wb_vec[I_SR1] ? wb_data : regs_q[I_SR1];
    assign O_SR2data = wb_vec[I_SR2] ? wb_data : regs_q[I_SR2];

    // A writeback landing this cycle retires one pending entry of its register.
    logic blk1, blk2;
    assign blk1 = I_SR1use && (cnt_q[I_SR1] > CNTW'(wb_vec[I_SR1]));
    assign blk2 = I_SR2use && (cnt_q[I_SR2] > CNTW'(wb_vec[I_SR2]));

    assign O_hazard = blk1 | blk2;
    assign O_CC     = cc_q;
    assign O_err    = err_q;

endmodule

// File: tb/tb_lc3_regfile_wb.sv
// Bench for lc3_regfile_wb: directed plan plus randomized traffic, checked
// against an array/integer model of the register file, codes and pending counts.
module tb_lc3_regfile_wb;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] wbctl;
    logic [2:0]  sr1, sr2, dr;
    logic        u1, u2, iss;
    logic [15:0] sr1data, sr2data;
    logic [2:0]  cc;
    logic        hazard, err;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_reg [8];
    int          m_cnt [8];
    logic [2:0]  m_cc;
    logic        m_err;

    lc3_regfile_wb #(.DW(16), .CNTW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .I_WBctl  (wbctl),
        .I_SR1    (sr1),
        .I_SR2    (sr2),
        .I_SR1use (u1),
        .I_SR2use (u2),
        .I_issue  (iss),
        .I_issueDR(dr),
        .O_SR1data(sr1data),
        .O_SR2data(sr2data),
        .O_CC     (cc),
        .O_hazard (hazard),
        .O_err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] s);
        if (wbctl[19] && wbctl[18:16] == s) return wbctl[15:0];
        return m_reg[s];
    endfunction

    function automatic logic m_blocked(input logic [2:0] s, input logic use_s);
        int pend;
        pend = m_cnt[s] - ((wbctl[19] && wbctl[18:16] == s) ? 1 : 0);
        return use_s && (pend > 0);
    endfunction

    // Drive one cycle's inputs and check the combinational outputs before the edge.
    task automatic apply(input logic r, input logic we, input logic [2:0] wr, input logic [15:0] wd,
                         input logic [2:0] s1, input logic [2:0] s2, input logic a1, input logic a2,
                         input logic is, input logic [2:0] d);
        reset = r; wbctl = {we, wr, wd};
        sr1 = s1; sr2 = s2; u1 = a1; u2 = a2; iss = is; dr = d;
        #1;
        chk("sr1data", 32'(sr1data), 32'(m_read(s1)));
        chk("sr2data", 32'(sr2data), 32'(m_read(s2)));
        chk("hazard", 32'(hazard), 32'(m_blocked(s1, a1) | m_blocked(s2, a2)));
    endtask

    // Advance the model by the applied inputs, clock, then check registered outputs.
    task automatic step();
        logic        we;
        logic [2:0]  wr;
        logic [15:0] wd;
        we = wbctl[19]; wr = wbctl[18:16]; wd = wbctl[15:0];
        if (reset) begin
            for (int i = 0; i < 8; i++) begin m_reg[i] = 16'h0; m_cnt[i] = 0; end
            m_cc = 3'b010; m_err = 1'b0;
        end else begin
            if (we) begin
                m_reg[wr] = wd;
                m_cc = wd[15] ? 3'b100 : (wd == 16'h0 ? 3'b010 : 3'b001);
            end
            if (!(iss && we && dr == wr)) begin
                if (iss) begin
                    if (m_cnt[dr] == MAXC) m_err = 1'b1; else m_cnt[dr]++;
                end
                if (we) begin
                    if (m_cnt[wr] == 0) m_err = 1'b1; else m_cnt[wr]--;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("cc", 32'(cc), 32'(m_cc));
        chk("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_reg[i] = 16'h0; m_cnt[i] = 0; end
        m_cc = 3'b010; m_err = 1'b0;
        reset = 1'b1; wbctl = '0; sr1 = '0; sr2 = '0; u1 = 0; u2 = 0; iss = 0; dr = '0;

        // Reset then read
        @(posedge clk); #1;
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        apply(0, 0, 0, 0, 3'd3, 3'd7, 0, 0, 0, 0);
        chk("rst_sr1", 32'(sr1data), 32'h0);
        chk("rst_sr2", 32'(sr2data), 32'h0);
        chk("rst_cc", 32'(cc), 32'(3'b010));
        chk("rst_hz", 32'(hazard), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        step();

        // Writes and condition codes
        apply(0, 1, 3'd5, 16'h8001, 0, 0, 0, 0, 0, 0); step();
        chk("cc_neg", 32'(cc), 32'(3'b100));
        apply(0, 1, 3'd2, 16'h0000, 3'd5, 3'd5, 0, 0, 0, 0);
        chk("r5_val", 32'(sr1data), 32'h8001);
        step();
        chk("cc_zero", 32'(cc), 32'(3'b010));
        apply(0, 1, 3'd2, 16'h0042, 0, 0, 0, 0, 0, 0); step();
        chk("cc_pos", 32'(cc), 32'(3'b001));

        // Bypass on both ports
        apply(0, 1, 3'd4, 16'h1111, 0, 0, 0, 0, 0, 0); step();
        apply(0, 1, 3'd4, 16'h2222, 3'd4, 3'd4, 0, 0, 0, 0);
        chk("byp_sr1", 32'(sr1data), 32'h2222);
        chk("byp_sr2", 32'(sr2data), 32'h2222);
        step();
        apply(0, 0, 0, 0, 3'd4, 3'd2, 0, 0, 0, 0);
        chk("r4_after", 32'(sr1data), 32'h2222);
        chk("r2_after", 32'(sr2data), 32'h0042);
        step();

        // Scoreboard hazard on R6
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd6); step();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd6); step();
        apply(0, 0, 0, 0, 3'd6, 0, 0, 0, 0, 0);
        chk("hz_nouse", 32'(hazard), 32'h0);
        step();
        apply(0, 0, 0, 0, 3'd6, 0, 1, 0, 0, 0);
        chk("hz_cnt2", 32'(hazard), 32'h1);
        step();
        apply(0, 1, 3'd6, 16'h0606, 3'd6, 0, 1, 0, 0, 0);
        chk("hz_wb1", 32'(hazard), 32'h1);
        step();
        apply(0, 1, 3'd6, 16'h6666, 3'd6, 0, 1, 0, 0, 0);
        chk("hz_wb2", 32'(hazard), 32'h0);
        chk("hz_wb2_data", 32'(sr1data), 32'h6666);
        step();

        // Simultaneous issue and writeback to R1
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd1); step();
        apply(0, 1, 3'd1, 16'h0101, 0, 0, 0, 0, 1, 3'd1); step();
        apply(0, 0, 0, 0, 3'd1, 3'd1, 1, 0, 0, 0);
        chk("r1_hz", 32'(hazard), 32'h1);
        chk("r1_err", 32'(err), 32'h0);
        step();

        // Writeback to R0 with nothing pending
        apply(0, 1, 3'd0, 16'hBEEF, 0, 0, 0, 0, 0, 0); step();
        chk("r0_err", 32'(err), 32'h1);
        apply(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        chk("r0_val", 32'(sr1data), 32'hBEEF);
        step();
        chk("r0_sticky", 32'(err), 32'h1);

        // Saturation on R3
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd3); step();
        end
        chk("sat_noerr", 32'(err), 32'h0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd3); step();
        chk("sat_err", 32'(err), 32'h1);
        apply(0, 1, 3'd3, 16'h0003, 0, 3'd3, 0, 1, 0, 0); step();
        apply(0, 1, 3'd3, 16'h0033, 0, 3'd3, 0, 1, 0, 0);
        chk("sat_hz2", 32'(hazard), 32'h1);
        step();
        apply(0, 1, 3'd3, 16'h0333, 0, 3'd3, 0, 1, 0, 0);
        chk("sat_hz3", 32'(hazard), 32'h0);
        step();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("rst_clr_err", 32'(err), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic        r, we, is, a1, a2;
            logic [2:0]  wr, d, s1, s2;
            logic [15:0] wd;
            r  = ($urandom_range(0, 49) == 0);
            wr = 3'($urandom_range(0, 7));
            we = (m_cnt[wr] > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       wd = 16'h0000;
                1:       wd = 16'h8000 | 16'($urandom_range(0, 65535));
                default: wd = 16'($urandom_range(0, 65535));
            endcase
            is = ($urandom_range(0, 2) == 0);
            d  = 3'($urandom_range(0, 7));
            s1 = ($urandom_range(0, 2) == 0) ? wr : 3'($urandom_range(0, 7));
            s2 = 3'($urandom_range(0, 7));
            a1 = 1'($urandom_range(0, 1));
            a2 = 1'($urandom_range(0, 1));
            apply(r, we, wr, wd, s1, s2, a1, a2, is, d);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
